// File: rtl/pf_issue_queue.sv
// Prefetch issue queue: drops redundant candidates, buffers survivors in order,
// issues them over valid/ready and cancels entries already demanded by the core.
module pf_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int RECENT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pf_v,
    input  logic [15:0] pf_addr,
    input  logic        dem_v,
    input  logic [15:0] dem_addr,
    output logic        mem_req_v,
    output logic [15:0] mem_req_addr,
    input  logic        mem_req_rdy,
    output logic [15:0] n_issued,
    output logic [15:0] n_filtered,
    output logic [15:0] n_full,
    output logic [15:0] n_cancel
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = (RECENT > 1) ? $clog2(RECENT) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [RW-1:0] REC_LAST = RW'(RECENT - 1);

    logic [15:0]       q_addr [DEPTH];
    logic [DEPTH-1:0]  q_live;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;

    logic [15:0]       rec_addr [RECENT];
    logic [RECENT-1:0] rec_v;
    logic [RW-1:0]     rec_ptr;

    logic              handshake;
    logic              pop;
    logic              dup;
    logic              filtered;
    logic              drop_full;
    logic              push;
    logic [DEPTH-1:0]  cancel_mask;
    logic [DEPTH-1:0]  live_nxt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Outputs come straight from registered state; the address is gated so it
    // reads zero whenever nothing is presented.
    assign mem_req_v    = q_live[head];
    assign mem_req_addr = mem_req_v ? q_addr[head] : 16'h0000;
    assign handshake    = mem_req_v & mem_req_rdy;
    assign pop          = handshake | (~mem_req_v & (count != '0));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        dup         = 1'b0;
        cancel_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_live[i] && q_addr[i] == pf_addr)
                dup = 1'b1;
            // The presented head stays put until handshake, even if demanded.
            if (dem_v && q_live[i] && q_addr[i] == dem_addr &&
                !(mem_req_v && PW'(i) == head))
                cancel_mask[i] = 1'b1;
        end
        for (int j = 0; j < RECENT; j++) begin
            if (rec_v[j] && rec_addr[j] == pf_addr)
                dup = 1'b1;
        end
        if (dem_v && dem_addr == pf_addr)
            dup = 1'b1;
    end

    assign filtered  = pf_v & dup;
    assign drop_full = pf_v & ~dup & (count == FULL_CNT) & ~pop;
    assign push      = pf_v & ~dup & ~drop_full;

    always_comb begin
        live_nxt = q_live & ~cancel_mask;
        if (pop)
            live_nxt[head] = 1'b0;
        if (push)
            live_nxt[tail] = 1'b1;
    end

    // NOTE: address payloads are not reset; the live/valid bits alone decide whether a slot means anything.
    always_ff @(posedge clk) begin
        if (push)
            q_addr[tail] <= pf_addr;
        if (handshake)
            rec_addr[rec_ptr] <= q_addr[head];
    end

    // NOTE: all state here uses non-blocking assignment so every register samples the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_live     <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            rec_v      <= '0;
            rec_ptr    <= '0;
            n_issued   <= '0;
            n_filtered <= '0;
            n_full     <= '0;
            n_cancel   <= '0;
        end else begin
            q_live <= live_nxt;
            if (pop)
                head <= head + PW'(1);
            if (push)
                tail <= tail + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);

            if (handshake) begin
                rec_v[rec_ptr] <= 1'b1;
                rec_ptr        <= (rec_ptr == REC_LAST) ? '0 : rec_ptr + RW'(1);
                n_issued       <= sat_inc(n_issued);
            end
            if (filtered)
                n_filtered <= sat_inc(n_filtered);
            if (drop_full)
                n_full <= sat_inc(n_full);
            if (|cancel_mask)
                n_cancel <= sat_inc(n_cancel);
        end
    end

endmodule

// File: tb/tb_pf_issue_queue.sv
// Bench for pf_issue_queue: directed scenarios plus random traffic, checked by a
// scoreboard fed from a queue-level reference model.
module tb_pf_issue_queue;

    localparam int DEPTH  = 4;
    localparam int RECENT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pf_v;
    logic [15:0] pf_addr;
    logic        dem_v;
    logic [15:0] dem_addr;
    logic        mem_req_v;
    logic [15:0] mem_req_addr;
    logic        mem_req_rdy;
    logic [15:0] n_issued;
    logic [15:0] n_filtered;
    logic [15:0] n_full;
    logic [15:0] n_cancel;

    pf_issue_queue #(.DEPTH(DEPTH), .RECENT(RECENT)) dut (
        .clk(clk), .rst_n(rst_n),
        .pf_v(pf_v), .pf_addr(pf_addr),
        .dem_v(dem_v), .dem_addr(dem_addr),
        .mem_req_v(mem_req_v), .mem_req_addr(mem_req_addr), .mem_req_rdy(mem_req_rdy),
        .n_issued(n_issued), .n_filtered(n_filtered), .n_full(n_full), .n_cancel(n_cancel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        bit          live;
    } entry_t;

    entry_t      mq[$];
    logic [15:0] mrec[$];
    logic [15:0] exp_q[$];
    int          m_issued, m_filtered, m_full, m_cancel;
    bit          exp_v;
    logic [15:0] exp_addr;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_reset();
        mq.delete();
        mrec.delete();
        exp_q.delete();
        m_issued = 0; m_filtered = 0; m_full = 0; m_cancel = 0;
        exp_v = 1'b0; exp_addr = '0;
    endtask

    // Advances the model across the coming clock edge using the inputs for it.
    task automatic step(input bit pv, input logic [15:0] pa, input bit dv,
                        input logic [15:0] da, input bit rdy);
        bit pres, pop, filt, push, any_cancel;
        pres = (mq.size() > 0) && mq[0].live;
        exp_v = pres;
        exp_addr = pres ? mq[0].addr : 16'h0000;
        pop = (mq.size() > 0) && (!mq[0].live || rdy);

        filt = 1'b0;
        if (pv) begin
            foreach (mq[i]) if (mq[i].live && mq[i].addr == pa) filt = 1'b1;
            foreach (mrec[i]) if (mrec[i] == pa) filt = 1'b1;
            if (dv && da == pa) filt = 1'b1;
        end

        any_cancel = 1'b0;
        if (dv) begin
            foreach (mq[i]) begin
                if (mq[i].live && mq[i].addr == da && !(i == 0 && pres)) begin
                    mq[i].live = 1'b0;
                    any_cancel = 1'b1;
                end
            end
        end
        if (any_cancel) m_cancel = sat(m_cancel);

        push = 1'b0;
        if (pv) begin
            if (filt) m_filtered = sat(m_filtered);
            else if (mq.size() == DEPTH && !pop) m_full = sat(m_full);
            else push = 1'b1;
        end

        if (pop) begin
            if (pres) begin
                exp_q.push_back(mq[0].addr);
                mrec.push_back(mq[0].addr);
                if (mrec.size() > RECENT) void'(mrec.pop_front());
                m_issued = sat(m_issued);
            end
            void'(mq.pop_front());
        end
        if (push) mq.push_back('{addr: pa, live: 1'b1});
    endtask

    // Called one step after a rising edge: drive, predict, then cross the next edge.
    task automatic cycle(input bit pv, input logic [15:0] pa, input bit dv,
                         input logic [15:0] da, input bit rdy);
        pf_v = pv; pf_addr = pa; dem_v = dv; dem_addr = da; mem_req_rdy = rdy;
        step(pv, pa, dv, da, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b0, 16'h0, rdy);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_n_issued"},   n_issued,   m_issued);
        check({tag, "_n_filtered"}, n_filtered, m_filtered);
        check({tag, "_n_full"},     n_full,     m_full);
        check({tag, "_n_cancel"},   n_cancel,   m_cancel);
    endtask

    // Monitor: compares presentation every cycle and pops the scoreboard on each handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("mon_req_v", mem_req_v, exp_v);
                if (exp_v) check("mon_req_addr", mem_req_addr, exp_addr);
                if (mem_req_v && mem_req_rdy) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL mon_issue: got unexpected issue %0h, expected none at %0t",
                                 mem_req_addr, $time);
                    end else begin
                        check("mon_issue_addr", mem_req_addr, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int base_f, base_full, base_c;
        rst_n = 1'b0;
        pf_v = 1'b0; pf_addr = '0; dem_v = 1'b0; dem_addr = '0; mem_req_rdy = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_v", mem_req_v, 0);
        check("rst_req_addr", mem_req_addr, 0);
        check_counters("rst");
        rst_n = 1'b1;

        // Latency: accepted at edge t, presented after t, issued at t+1.
        idle(6, 1'b1);
        cycle(1'b1, 16'h0010, 1'b0, 16'h0, 1'b1);
        check("lat_req_v", mem_req_v, 1);
        check("lat_req_addr", mem_req_addr, 16'h0010);
        cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        check("lat_n_issued", n_issued, 1);

        // Dedup against live entries, then against the recent filter.
        base_f = m_filtered;
        cycle(1'b1, 16'h0011, 1'b0, 16'h0, 1'b0);
        cycle(1'b1, 16'h0011, 1'b0, 16'h0, 1'b0);
        cycle(1'b1, 16'h0012, 1'b0, 16'h0, 1'b0);
        check("dedup_filtered1", n_filtered, base_f + 1);
        idle(3, 1'b1);
        cycle(1'b1, 16'h0011, 1'b0, 16'h0, 1'b1);
        check("dedup_filtered2", n_filtered, base_f + 2);
        check_counters("dedup");

        // Full: fifth candidate dropped, head address held while stalled.
        base_full = m_full;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 16'h0020 + 16'(i), 1'b0, 16'h0, 1'b0);
            check("full_head_addr", mem_req_addr, 16'h0020);
        end
        check("full_n_full", n_full, base_full + 1);
        idle(6, 1'b1);
        check_counters("full");

        // Cancel: non-presented 0x31 cancelled, presented 0x30 immune.
        base_c = m_cancel;
        cycle(1'b1, 16'h0030, 1'b0, 16'h0, 1'b0);
        cycle(1'b1, 16'h0031, 1'b0, 16'h0, 1'b0);
        cycle(1'b1, 16'h0032, 1'b0, 16'h0, 1'b0);
        cycle(1'b0, 16'h0, 1'b1, 16'h0031, 1'b0);
        cycle(1'b0, 16'h0, 1'b1, 16'h0030, 1'b0);
        check("cancel_n_cancel", n_cancel, base_c + 1);
        check("cancel_head", mem_req_addr, 16'h0030);
        idle(5, 1'b1);
        check_counters("cancel");

        // Push and pop together at full occupancy.
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'h0040 + 16'(i), 1'b0, 16'h0, 1'b0);
        base_full = m_full;
        cycle(1'b1, 16'h0044, 1'b0, 16'h0, 1'b1);
        check("pp_n_full_same", n_full, base_full);
        cycle(1'b1, 16'h0045, 1'b0, 16'h0, 1'b0);
        check("pp_still_full", n_full, base_full + 1);
        idle(6, 1'b1);
        check_counters("pushpop");

        // Asynchronous reset between edges with three entries queued.
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0050 + 16'(i), 1'b0, 16'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        pf_v = 1'b0; dem_v = 1'b0; mem_req_rdy = 1'b1;
        #1;
        model_reset();
        check("arst_req_v", mem_req_v, 0);
        check_counters("arst");
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(5, 1'b1);
        check("arst_n_issued", n_issued, 0);

        // Random traffic over a small address window to provoke collisions.
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 9) < 7, 16'h0100 + 16'($urandom_range(0, 11)),
                  $urandom_range(0, 9) < 3, 16'h0100 + 16'($urandom_range(0, 11)),
                  $urandom_range(0, 1) == 1);
            check_counters("rand");
        end
        idle(8, 1'b1);
        check_counters("final");
        check("final_sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
